// File: rtl/rv_pkg.sv
// ============================================================================
// rv_pkg: shared types and widths for the IMEM loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int XLEN           = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = XLEN / BYTE_W;
  localparam int BCNT_W         = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_word_packer.sv
// ============================================================================
// byte_word_packer: assembles little-endian bytes into 32-bit words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_word_packer
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              last_o,
  output logic [XLEN-1:0]   word_nxt_o,
  output logic [XLEN-1:0]   word_o,
  output logic              word_valid_o
);

  logic [BCNT_W-1:0] byte_cnt_q;
  logic [XLEN-1:0]   shift_q;
  logic [XLEN-1:0]   word_q;
  logic              word_valid_q;

  assign last_o       = (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  // Bytes enter at the top, so the first byte of a word ends up in [7:0].
  assign word_nxt_o   = {byte_i, shift_q[XLEN-1:BYTE_W]};
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clr_i) begin
        byte_cnt_q <= '0;
        shift_q    <= '0;
      end else if (byte_vld_i) begin
        shift_q    <= word_nxt_o;
        byte_cnt_q <= byte_cnt_q + 1'b1;
        if (last_o) begin
          word_q       <= word_nxt_o;
          word_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader: streams a length-prefixed program image into IMEM, holding the
// core until done. Optional trailing XOR checksum byte: CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader
  import rv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] CAP = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
`ifdef CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = CSUM;
`else
  localparam loader_state_t AFTER_DATA = DONE;
`endif

  loader_state_t     state_q, state_d;
  logic              rx_ready_q, hold_q, done_q, err_q;
  logic              data_q;
  logic [ADDR_W:0]   idx_q, len_q;
  logic [ADDR_W-1:0] addr_q;
`ifdef CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
`endif

  logic              acc, start_ok, last, word_valid;
  logic [XLEN-1:0]   word_nxt, word;

  assign acc      = rx_valid & rx_ready_q;
  assign start_ok = start & (state_q inside {IDLE, DONE, ERR});

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .byte_vld_i   (acc),
    .byte_i       (rx_data),
    .last_o       (last),
    .word_nxt_o   (word_nxt),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // data_q tags the word in flight so the length word never reaches IMEM.
  assign imem_we    = word_valid & data_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign rx_ready   = rx_ready_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN;
      LEN: begin
        if (acc && last) begin
          if ({1'b0, word_nxt} > CAP) state_d = ERR;
          else if (word_nxt == '0)    state_d = AFTER_DATA;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        if (acc && last && (idx_q == len_q - 1'b1)) state_d = AFTER_DATA;
      end
`ifdef CHECKSUM_EN
      CSUM: if (acc) state_d = (rx_data == csum_q) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
`ifdef CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= state_d inside {LEN, DATA, CSUM};
      hold_q     <= (state_d != DONE);
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERR);
      if (acc) data_q <= (state_q == DATA);
      if (state_q == LEN && acc && last) len_q <= word_nxt[ADDR_W:0];
      if (start_ok) begin
        idx_q  <= '0;
        addr_q <= ADDR_W'(BASE_ADDR);
      end else if (imem_we) begin
        idx_q  <= idx_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
`ifdef CHECKSUM_EN
      if (start_ok)                     csum_q <= '0;
      else if (acc && state_q == DATA)  csum_q <= csum_q ^ rx_data;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader: table-driven loads with a write scoreboard for imem_loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                last;
  } wr_t;

  typedef struct {
    logic [31:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gap;
    bit          bad_csum;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[$];
  wr_t  mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next expected write in order.
  always @(negedge clk) begin
    if (imem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("we_addr", 32'(imem_addr), 32'(mon_e.addr));
        chk("we_data", imem_wdata, mon_e.data);
        chk("we_done_coincide", {31'd0, done}, {31'd0, mon_e.last});
      end
    end
  end

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return {i[15:0], ~i[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      tick();
      t++;
    end
    if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_we"},       {31'd0, imem_we},  32'd0);
    chk({tag, "_addr"},     32'(imem_addr),    32'd0);
    chk({tag, "_wdata"},    imem_wdata,        32'd0);
    chk({tag, "_hold"},     {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"},     {31'd0, done},     32'd0);
    chk({tag, "_err"},      {31'd0, err},      32'd0);
  endtask

  task automatic wait_end(input bit exp_err);
    int t = 0;
    while (!(done | err) && t < 200) begin
      tick();
      t++;
    end
    @(negedge clk);
    #1;
    chk("end_done",     {31'd0, done},     {31'd0, !exp_err});
    chk("end_err",      {31'd0, err},      {31'd0, exp_err});
    chk("end_hold",     {31'd0, cpu_hold}, {31'd0, exp_err});
    chk("end_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("end_sb_empty", 32'(sb.size()),    32'd0);
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] w;
    logic [7:0]  cs;
    bit          len_err;
    int          nw;
    cs      = 8'h00;
    len_err = (v.len > 32'(DEPTH));
    nw      = len_err ? 0 : int'(v.len);
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(v.len[8*k +: 8], v.gap);
    for (int i = 0; i < nw; i++) begin
      w = word_of(v, i);
      sb.push_back('{addr: ADDR_W'(i), data: w, last: (i == nw - 1) && !CS});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], v.gap);
        cs = cs ^ w[8*k +: 8];
      end
    end
    if (CS && !len_err) send_byte(v.bad_csum ? (cs ^ 8'h01) : cs, v.gap);
    wait_end(len_err || (CS && v.bad_csum));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    vecs.push_back('{len: 32'd2,     w0: 32'h0000_0013, w1: 32'h0010_0093, gap: 1'b0, bad_csum: 1'b0});
    vecs.push_back('{len: 32'd2,     w0: 32'h0000_0013, w1: 32'h0010_0093, gap: 1'b1, bad_csum: 1'b0});
    vecs.push_back('{len: 32'd0,     w0: 32'h0,         w1: 32'h0,         gap: 1'b0, bad_csum: 1'b0});
    vecs.push_back('{len: 32'h401,   w0: 32'h0,         w1: 32'h0,         gap: 1'b0, bad_csum: 1'b0});
    vecs.push_back('{len: 32'd1,     w0: 32'hDEAD_BEEF, w1: 32'h0,         gap: 1'b0, bad_csum: 1'b0});
    vecs.push_back('{len: 32'd1024,  w0: 32'hA5A5_0001, w1: 32'h1234_5678, gap: 1'b0, bad_csum: 1'b0});
    vecs.push_back('{len: 32'hFFFF_FFFF, w0: 32'h0,     w1: 32'h0,         gap: 1'b1, bad_csum: 1'b0});
    vecs.push_back('{len: 32'd3,     w0: 32'h0102_0304, w1: 32'hF0E0_D0C0, gap: 1'b1, bad_csum: 1'b0});
`ifdef CHECKSUM_EN
    vecs.push_back('{len: 32'd1,     w0: 32'h0000_0013, w1: 32'h0,         gap: 1'b0, bad_csum: 1'b0});
    vecs.push_back('{len: 32'd1,     w0: 32'h0000_0013, w1: 32'h0,         gap: 1'b0, bad_csum: 1'b1});
    vecs.push_back('{len: 32'd2,     w0: 32'h0000_0013, w1: 32'h0010_0093, gap: 1'b0, bad_csum: 1'b0});
`endif

    // Reset state, both while held and after release with no start.
    repeat (3) tick();
    check_idle_outputs("in_reset");
    rst = 1'b0;
    repeat (10) tick();
    check_idle_outputs("idle");

    foreach (vecs[i]) run_vec(vecs[i]);

    // start mid-load is ignored; rst after 5 data bytes drops everything.
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 2 : 0), 1'b0);
    sb.push_back('{addr: '0, data: 32'h0000_0013, last: 1'b0});
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    tick();
    chk("partial_write_seen", 32'(sb.size()), 32'd0);
    chk("partial_hold",       {31'd0, cpu_hold}, 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    v = vecs[0];
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
